calibration_sequencer: RTL and testbench

Top-level controller for the LED-address calibration pass. For each bit b of the LED address it asks the LED pattern driver to light every LED with colour 0 or 1 according to address bit b. It then fires one calibration step (shift-accumulate capture) and waits for that step to finish before moving to the next bit. It also arbitrates the accumulator's read port, giving external readout access only while no capture sequence is running.

---
 rtl/calibration_pkg.sv | 31 +++
 rtl/calibration_sequencer.sv | 144 ++++++++++++++
 tb/tb_calibration_sequencer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/calibration_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calibration_pkg
// Description : Shared types and defaults for the LED-address calibration pass.
// Revision    : 1.0 - initial release
// ============================================================================
package calibration_pkg;

    localparam int C_LED_ADDRESS_WIDTH   = 10;
    localparam int C_STEP_TIMEOUT_CYCLES = 50_000_000;

    // Encoding is shared with the step FSM; values must not change.
    typedef enum logic [1:0] {
        STEP_IDLE            = 2'd0,
        STEP_WAIT_FOR_CAM    = 2'd1,
        STEP_WAIT_FOR_NFRAME = 2'd2,
        STEP_CAPTURE_FRAME   = 2'd3
    } calibration_step_state_t;

    typedef enum logic [2:0] {
        SEQ_IDLE  = 3'd0,
        SEQ_LOAD  = 3'd1,
        SEQ_FIRE  = 3'd2,
        SEQ_ACK   = 3'd3,
        SEQ_RUN   = 3'd4,
        SEQ_DONE  = 3'd5,
        SEQ_ERROR = 3'd6
    } calibration_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/calibration_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : calibration_sequencer
// Description : Walks every LED address bit through pattern load and one
//               calibration step, and arbitrates the accumulator read port.
// Revision    : 1.0 - initial release
// ============================================================================
module calibration_sequencer
    import calibration_pkg::*;
#(
    parameter int  LED_ADDRESS_WIDTH   = C_LED_ADDRESS_WIDTH,
    parameter int  STEP_TIMEOUT_CYCLES = C_STEP_TIMEOUT_CYCLES,
    localparam int BIT_INDEX_WIDTH     = (LED_ADDRESS_WIDTH > 1) ? $clog2(LED_ADDRESS_WIDTH) : 1,
    localparam int TIMEOUT_WIDTH       = $clog2(STEP_TIMEOUT_CYCLES + 1)
) (
    input  logic                       clk_pixel,
    input  logic                       rst_n,
    input  logic                       start_in,
    input  logic                       abort_in,
    output logic [BIT_INDEX_WIDTH-1:0] pattern_bit_out,
    output logic                       pattern_valid_out,
    input  logic                       pattern_ready_in,
    output logic                       start_calibration_step_out,
    output logic                       should_overwrite_latch_out,
    input  logic [1:0]                 step_state_in,
    input  logic                       rd_req_in,
    output logic                       rd_grant_out,
    output logic                       read_request_out,
    output logic                       busy_out,
    output logic                       done_out,
    output logic                       error_out
);

    localparam logic [BIT_INDEX_WIDTH-1:0] c_last_bit      = BIT_INDEX_WIDTH'(LED_ADDRESS_WIDTH - 1);
    localparam logic [TIMEOUT_WIDTH-1:0]   c_timeout_limit = TIMEOUT_WIDTH'(STEP_TIMEOUT_CYCLES - 1);

    calibration_seq_state_t        r_state, w_state_next;
    logic [BIT_INDEX_WIDTH-1:0]    r_bit, w_bit_next;
    logic [TIMEOUT_WIDTH-1:0]      r_timeout, w_timeout_next;
    logic                          r_start_q;
    logic                          r_done, w_done_next;
    logic                          r_error, w_error_next;

    logic                          w_start_edge;
    logic                          w_step_idle;
    logic                          w_busy;
    calibration_step_state_t       w_step_state;

    assign w_step_state = calibration_step_state_t'(step_state_in);
    assign w_step_idle  = (w_step_state == STEP_IDLE);
    assign w_start_edge = start_in && !r_start_q;
    assign w_busy       = (r_state == SEQ_LOAD) || (r_state == SEQ_FIRE) ||
                          (r_state == SEQ_ACK)  || (r_state == SEQ_RUN);

    always_comb begin
        w_state_next   = r_state;
        w_bit_next     = r_bit;
        w_timeout_next = r_timeout;
        w_done_next    = r_done;
        w_error_next   = r_error;

        if (abort_in) begin
            // Abort from a finished state keeps the sticky result flags.
            w_state_next = SEQ_IDLE;
            if (w_busy) begin
                w_done_next = 1'b0;
            end
        end else begin
            case (r_state)
                SEQ_IDLE, SEQ_DONE, SEQ_ERROR: begin
                    if (w_start_edge) begin
                        w_bit_next   = '0;
                        w_done_next  = 1'b0;
                        w_error_next = 1'b0;
                        w_state_next = SEQ_LOAD;
                    end
                end
                SEQ_LOAD: begin
                    if (pattern_ready_in) begin
                        w_state_next = SEQ_FIRE;
                    end
                end
                SEQ_FIRE: begin
                    w_timeout_next = '0;
                    w_state_next   = SEQ_ACK;
                end
                SEQ_ACK, SEQ_RUN: begin
                    // Completion on the limit cycle beats the timeout.
                    if ((r_state == SEQ_RUN) && w_step_idle) begin
                        if (r_bit == c_last_bit) begin
                            w_done_next  = 1'b1;
                            w_state_next = SEQ_DONE;
                        end else begin
                            w_bit_next   = r_bit + BIT_INDEX_WIDTH'(1);
                            w_state_next = SEQ_LOAD;
                        end
                    end else if (r_timeout == c_timeout_limit) begin
                        w_error_next = 1'b1;
                        w_state_next = SEQ_ERROR;
                    end else begin
                        w_timeout_next = r_timeout + TIMEOUT_WIDTH'(1);
                        if ((r_state == SEQ_ACK) && !w_step_idle) begin
                            w_state_next = SEQ_RUN;
                        end
                    end
                end
                default: begin
                    w_state_next = SEQ_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= SEQ_IDLE;
            r_bit     <= '0;
            r_timeout <= '0;
            r_start_q <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bit     <= w_bit_next;
            r_timeout <= w_timeout_next;
            r_start_q <= start_in;
            r_done    <= w_done_next;
            r_error   <= w_error_next;
        end
    end

    assign pattern_bit_out            = r_bit;
    assign pattern_valid_out          = (r_state == SEQ_LOAD);
    assign start_calibration_step_out = (r_state == SEQ_FIRE);
    assign should_overwrite_latch_out = (r_state == SEQ_FIRE) && (r_bit == '0);
    assign busy_out                   = w_busy;
    assign done_out                   = r_done;
    assign error_out                  = r_error;
    // Requests during a pass are refused outright; the requester retries.
    assign rd_grant_out               = rd_req_in && !w_busy;
    assign read_request_out           = rd_req_in && !w_busy;

endmodule
`default_nettype wire

// File: tb/tb_calibration_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_calibration_sequencer
// Description : Self-checking bench for calibration_sequencer (4 address bits,
//               16-cycle step timeout) with a behavioural step FSM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calibration_sequencer;
    import calibration_pkg::*;

    typedef struct packed {
        logic [1:0] bit_idx;
        logic       ow;
    } exp_t;

    logic       clk_pixel = 1'b0;
    logic       rst_n;
    logic       start_in;
    logic       abort_in;
    logic [1:0] pattern_bit_out;
    logic       pattern_valid_out;
    logic       pattern_ready_in;
    logic       start_calibration_step_out;
    logic       should_overwrite_latch_out;
    logic [1:0] step_state_in;
    logic       rd_req_in;
    logic       rd_grant_out;
    logic       read_request_out;
    logic       busy_out;
    logic       done_out;
    logic       error_out;
    logic [9:0] w_outs;

    int   total = 0;
    int   bad = 0;
    int   n_pulses = 0;
    logic prev_pulse = 1'b0;
    exp_t sb[$];

    calibration_step_state_t m_state;
    int   m_cnt;
    int   m_delay = 10;
    logic m_stick = 1'b0;

    calibration_sequencer #(
        .LED_ADDRESS_WIDTH   (4),
        .STEP_TIMEOUT_CYCLES (16)
    ) dut (
        .clk_pixel                  (clk_pixel),
        .rst_n                      (rst_n),
        .start_in                   (start_in),
        .abort_in                   (abort_in),
        .pattern_bit_out            (pattern_bit_out),
        .pattern_valid_out          (pattern_valid_out),
        .pattern_ready_in           (pattern_ready_in),
        .start_calibration_step_out (start_calibration_step_out),
        .should_overwrite_latch_out (should_overwrite_latch_out),
        .step_state_in              (step_state_in),
        .rd_req_in                  (rd_req_in),
        .rd_grant_out               (rd_grant_out),
        .read_request_out           (read_request_out),
        .busy_out                   (busy_out),
        .done_out                   (done_out),
        .error_out                  (error_out)
    );

    always #5 clk_pixel = ~clk_pixel;

    assign w_outs = {pattern_valid_out, pattern_bit_out, start_calibration_step_out,
                     should_overwrite_latch_out, rd_grant_out, read_request_out,
                     busy_out, done_out, error_out};

    // Step FSM model: leaves IDLE the edge after a pulse, returns m_delay cycles later.
    always @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= STEP_IDLE;
            m_cnt   <= 0;
        end else if (start_calibration_step_out) begin
            m_state <= STEP_CAPTURE_FRAME;
            m_cnt   <= m_delay - 1;
        end else if (m_state != STEP_IDLE && !m_stick) begin
            if (m_cnt == 0) m_state <= STEP_IDLE;
            else            m_cnt   <= m_cnt - 1;
        end
    end
    assign step_state_in = m_state;

    // Scoreboard consumer: every step pulse must match the next expected bit/overwrite.
    always @(negedge clk_pixel) begin
        if (rst_n === 1'b1 && start_calibration_step_out === 1'b1) begin
            exp_t e;
            n_pulses++;
            total++;
            if (prev_pulse) begin
                bad++;
                $display("FAIL pulse_width: step pulse high two cycles running, got=1 want=0");
            end
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: bit=%0d ow=%b, none expected", pattern_bit_out, should_overwrite_latch_out);
            end else begin
                e = sb.pop_front();
                if ({pattern_bit_out, should_overwrite_latch_out} !== {e.bit_idx, e.ow}) begin
                    bad++;
                    $display("FAIL pulse_fields: got bit=%0d ow=%b want bit=%0d ow=%b",
                             pattern_bit_out, should_overwrite_latch_out, e.bit_idx, e.ow);
                end
            end
        end
        prev_pulse = (rst_n === 1'b1) && (start_calibration_step_out === 1'b1);
    end

    task automatic push_pass(input int n_bits);
        for (int b = 0; b < n_bits; b++) begin
            exp_t e;
            e.bit_idx = 2'(b);
            e.ow      = (b == 0);
            sb.push_back(e);
        end
    endtask

    task automatic pulse_start();
        start_in = 1'b1;
        @(negedge clk_pixel);
        start_in = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy_out === 1'b1 && n < budget) begin
            @(negedge clk_pixel);
            n++;
        end
        total++;
        if (busy_out !== 1'b0) begin
            bad++;
            $display("FAIL %s_wait: busy=%b still after %0d cycles, want 0", tag, busy_out, budget);
        end
    endtask

    task automatic wait_pulse(input string tag, input logic [1:0] want_bit, input int budget);
        int n = 0;
        while (!(start_calibration_step_out === 1'b1 && pattern_bit_out === want_bit) && n < budget) begin
            @(negedge clk_pixel);
            n++;
        end
        total++;
        if (start_calibration_step_out !== 1'b1) begin
            bad++;
            $display("FAIL %s_pulse_wait: no pulse for bit %0d in %0d cycles", tag, want_bit, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_in = 1'b0; abort_in = 1'b0;
        pattern_ready_in = 1'b1; rd_req_in = 1'b0;
        repeat (3) @(negedge clk_pixel);
        total++;
        if (w_outs !== 10'b0) begin
            bad++;
            $display("FAIL reset_outputs: got=%b want=%b", w_outs, 10'b0);
        end
        rst_n = 1'b1;
        @(negedge clk_pixel);
        total++;
        if (w_outs !== 10'b0 || dut.r_state !== SEQ_IDLE) begin
            bad++;
            $display("FAIL reset_release: outs=%b state=%0d want outs=0 state=IDLE", w_outs, dut.r_state);
        end
    endtask

    task automatic test_full_pass();
        int p0 = n_pulses;
        m_delay = 10; m_stick = 1'b0; pattern_ready_in = 1'b1;
        push_pass(4);
        pulse_start();
        repeat (15) @(negedge clk_pixel);
        total++;
        if (busy_out !== 1'b1) begin
            bad++;
            $display("FAIL full_busy_mid: got=%b want=1", busy_out);
        end
        pulse_start();  // start edge while busy must be ignored
        wait_idle("full_pass", 500);
        total++;
        if ({done_out, error_out, busy_out} !== 3'b100) begin
            bad++;
            $display("FAIL full_flags: done/err/busy got=%b want=100", {done_out, error_out, busy_out});
        end
        total++;
        if (n_pulses - p0 != 4 || sb.size() != 0) begin
            bad++;
            $display("FAIL full_pulse_count: got=%0d left=%0d want 4 and 0", n_pulses - p0, sb.size());
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        m_delay = 10; pattern_ready_in = 1'b1;
        push_pass(4);
        pulse_start();
        wait_pulse("bp_bit0", 2'd0, 50);
        pattern_ready_in = 1'b0;
        while (pattern_valid_out !== 1'b1 && n < 50) begin
            @(negedge clk_pixel);
            n++;
        end
        for (int i = 0; i < 7; i++) begin
            total++;
            if ({pattern_valid_out, pattern_bit_out, start_calibration_step_out} !== 4'b1010) begin
                bad++;
                $display("FAIL bp_hold_%0d: valid/bit/pulse got=%b want=1010", i,
                         {pattern_valid_out, pattern_bit_out, start_calibration_step_out});
            end
            @(negedge clk_pixel);
        end
        pattern_ready_in = 1'b1;
        total++;
        if ({pattern_valid_out, pattern_bit_out, start_calibration_step_out} !== 4'b1010) begin
            bad++;
            $display("FAIL bp_ready_cycle: got=%b want=1010",
                     {pattern_valid_out, pattern_bit_out, start_calibration_step_out});
        end
        @(negedge clk_pixel);
        total++;
        if ({start_calibration_step_out, pattern_valid_out} !== 2'b10) begin
            bad++;
            $display("FAIL bp_fire_after_ready: pulse/valid got=%b want=10",
                     {start_calibration_step_out, pattern_valid_out});
        end
        wait_idle("bp", 500);
        total++;
        if (done_out !== 1'b1 || sb.size() != 0) begin
            bad++;
            $display("FAIL bp_done: done=%b left=%0d want 1 and 0", done_out, sb.size());
        end
    endtask

    task automatic test_timeout();
        logic early = 1'b0;
        m_stick = 1'b1; pattern_ready_in = 1'b1;
        push_pass(1);
        pulse_start();
        wait_pulse("to", 2'd0, 50);
        // Counter runs 0..15 over the 16 cycles following FIRE; flag rises after the 16th.
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk_pixel);
            if (error_out !== 1'b0) early = 1'b1;
        end
        total++;
        if (early) begin
            bad++;
            $display("FAIL to_early: error_out got=1 within 16 cycles of FIRE want=0");
        end
        @(negedge clk_pixel);
        total++;
        if ({error_out, done_out, busy_out} !== 3'b100) begin
            bad++;
            $display("FAIL to_flags: err/done/busy got=%b want=100", {error_out, done_out, busy_out});
        end
        total++;
        if (dut.r_state !== SEQ_ERROR) begin
            bad++;
            $display("FAIL to_state: got=%0d want=%0d", dut.r_state, SEQ_ERROR);
        end
        m_stick = 1'b0; m_delay = 10;
        push_pass(4);
        pulse_start();
        total++;
        if ({error_out, pattern_valid_out, pattern_bit_out} !== 4'b0100) begin
            bad++;
            $display("FAIL to_restart: err/valid/bit got=%b want=0100",
                     {error_out, pattern_valid_out, pattern_bit_out});
        end
        wait_idle("to_restart", 500);
        total++;
        if ({done_out, error_out} !== 2'b10 || sb.size() != 0) begin
            bad++;
            $display("FAIL to_restart_done: done/err got=%b left=%0d want 10 and 0", {done_out, error_out}, sb.size());
        end
    endtask

    task automatic test_timeout_boundary();
        // Step returns to IDLE on the very cycle the counter hits its limit.
        m_delay = 15; pattern_ready_in = 1'b1;
        push_pass(4);
        pulse_start();
        wait_idle("tob", 500);
        total++;
        if ({done_out, error_out} !== 2'b10 || sb.size() != 0) begin
            bad++;
            $display("FAIL tob_flags: done/err got=%b left=%0d want 10 and 0", {done_out, error_out}, sb.size());
        end
        m_delay = 10;
    endtask

    task automatic test_abort();
        int p0;
        m_delay = 10; pattern_ready_in = 1'b1;
        push_pass(3);
        pulse_start();
        wait_pulse("ab", 2'd2, 200);
        repeat (2) @(negedge clk_pixel);
        total++;
        if (dut.r_state !== SEQ_RUN) begin
            bad++;
            $display("FAIL ab_in_run: state got=%0d want=%0d", dut.r_state, SEQ_RUN);
        end
        abort_in = 1'b1;
        @(negedge clk_pixel);
        abort_in = 1'b0;
        total++;
        if ({busy_out, pattern_valid_out, done_out, start_calibration_step_out} !== 4'b0000 ||
            dut.r_state !== SEQ_IDLE) begin
            bad++;
            $display("FAIL ab_idle: busy/valid/done/pulse got=%b state=%0d want 0000 IDLE",
                     {busy_out, pattern_valid_out, done_out, start_calibration_step_out}, dut.r_state);
        end
        p0 = n_pulses;
        repeat (60) @(negedge clk_pixel);
        total++;
        if (n_pulses != p0 || done_out !== 1'b0 || sb.size() != 0) begin
            bad++;
            $display("FAIL ab_quiet: pulses=%0d done=%b left=%0d want 0 0 0", n_pulses - p0, done_out, sb.size());
        end
    endtask

    task automatic test_read_arb();
        logic seen_busy = 1'b0;
        int   n = 0;
        m_delay = 10; pattern_ready_in = 1'b1; rd_req_in = 1'b1;
        push_pass(4);
        @(negedge clk_pixel);
        total++;
        if ({rd_grant_out, read_request_out, busy_out} !== 3'b110) begin
            bad++;
            $display("FAIL rd_before: grant/req/busy got=%b want=110", {rd_grant_out, read_request_out, busy_out});
        end
        pulse_start();
        while (n < 500) begin
            total++;
            if (rd_grant_out !== ~busy_out || read_request_out !== ~busy_out) begin
                bad++;
                $display("FAIL rd_cycle_%0d: grant=%b req=%b busy=%b want grant=req=!busy",
                         n, rd_grant_out, read_request_out, busy_out);
            end
            if (busy_out === 1'b1) seen_busy = 1'b1;
            else if (seen_busy) break;
            @(negedge clk_pixel);
            n++;
        end
        total++;
        if (!seen_busy || {busy_out, rd_grant_out, done_out} !== 3'b011) begin
            bad++;
            $display("FAIL rd_after: seen_busy=%b busy/grant/done got=%b want 1 and 011",
                     seen_busy, {busy_out, rd_grant_out, done_out});
        end
        rd_req_in = 1'b0;
    endtask

    task automatic test_async_reset();
        pattern_ready_in = 1'b0; rd_req_in = 1'b0;
        pulse_start();
        total++;
        if (pattern_valid_out !== 1'b1) begin
            bad++;
            $display("FAIL ar_load: valid got=%b want=1", pattern_valid_out);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (w_outs !== 10'b0 || dut.r_state !== SEQ_IDLE) begin
            bad++;
            $display("FAIL ar_immediate: outs=%b state=%0d want 0 IDLE", w_outs, dut.r_state);
        end
        @(negedge clk_pixel);
        rst_n = 1'b1;
        pattern_ready_in = 1'b1;
        @(negedge clk_pixel);
        total++;
        if (w_outs !== 10'b0 || sb.size() != 0) begin
            bad++;
            $display("FAIL ar_after: outs=%b left=%0d want 0 and 0", w_outs, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_backpressure();
        test_timeout();
        test_timeout_boundary();
        test_abort();
        test_read_arb();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
